// File: rtl/pb_channel_sequencer.sv
// Single-channel sample playback engine: loads 1-bit samples into an external
// RAM while idle, then replays samples 0..stop on dout, each held hp clocks.
module pb_channel_sequencer #(
  parameter int ADDR_W = 20,
  parameter int HP_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              playback_en,
  input  logic              din,
  input  logic              write_addr,
  input  logic              write_stop_addr,
  input  logic              write_ram,
  input  logic              write_hp,
  input  logic              loop_pb,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] stop_addr_in,
  input  logic              ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_wdata,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] stop;
  logic [ADDR_W-1:0] cur;
  logic [HP_W-1:0]   hp;
  logic [HP_W-1:0]   cnt;
  logic              nbit;

  logic pe_q, wa_q, ws_q, wr_q, wh_q;
  logic pe_edge, wa_edge, ws_edge, wr_edge, wh_edge;
  logic cfg_ok, abort;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] nxt_cur;
  logic [ADDR_W-1:0] nxt_nxt_cur;
  logic [HP_W-1:0]   hp_clamped;

  function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a,
                                            input logic [ADDR_W-1:0] s);
    return (a == s) ? '0 : a + ADDR_W'(1);
  endfunction

  always_comb begin
    pe_edge     = playback_en & ~pe_q;
    wa_edge     = write_addr & ~wa_q;
    ws_edge     = write_stop_addr & ~ws_q;
    wr_edge     = write_ram & ~wr_q;
    wh_edge     = write_hp & ~wh_q;
    cfg_ok      = (state == IDLE) && !mode;
    abort       = !playback_en || !mode;
    // A same-cycle pointer load takes effect for the write it accompanies.
    wr_base     = wa_edge ? addr_in : wr_ptr;
    hp_clamped  = (addr_in[HP_W-1:0] < HP_W'(2)) ? HP_W'(2) : addr_in[HP_W-1:0];
    nxt_cur     = nxt(cur, stop);
    nxt_nxt_cur = nxt(nxt_cur, stop);
  end

  // NOTE: every register here is assigned with <= so all updates in this block
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      stop      <= '0;
      hp        <= HP_W'(2);
      cur       <= '0;
      cnt       <= '0;
      nbit      <= 1'b0;
      pe_q      <= 1'b0;
      wa_q      <= 1'b0;
      ws_q      <= 1'b0;
      wr_q      <= 1'b0;
      wh_q      <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= 1'b0;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pe_q   <= playback_en;
      wa_q   <= write_addr;
      ws_q   <= write_stop_addr;
      wr_q   <= write_ram;
      wh_q   <= write_hp;
      ram_we <= 1'b0;

      if (state != IDLE && abort) begin
        state <= IDLE;
        dout  <= 1'b0;
        done  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_ok) begin
              if (wa_edge) wr_ptr <= addr_in;
              if (ws_edge) stop   <= stop_addr_in;
              if (wh_edge) hp     <= hp_clamped;
              if (wr_edge) begin
                ram_we    <= 1'b1;
                ram_addr  <= wr_base;
                ram_wdata <= din;
                wr_ptr    <= wr_base + ADDR_W'(1);
              end
            end else if (mode && pe_edge) begin
              state    <= PRIME;
              ram_addr <= '0;
              cur      <= '0;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end

          PRIME: begin
            state    <= RUN;
            dout     <= ram_rdata;
            cnt      <= hp - HP_W'(1);
            ram_addr <= nxt('0, stop);
          end

          RUN: begin
            // ram_addr runs one sample ahead so nbit is ready at the hold boundary.
            nbit <= ram_rdata;
            if (cnt != '0) begin
              cnt <= cnt - HP_W'(1);
            end else if (cur != stop || loop_pb) begin
              dout     <= nbit;
              cur      <= nxt_cur;
              ram_addr <= nxt_nxt_cur;
              cnt      <= hp - HP_W'(1);
            end else begin
              state <= DONE;
              dout  <= 1'b0;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end

          DONE: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pb_channel_sequencer.sv
// Directed bench for pb_channel_sequencer with a behavioural sample RAM whose
// read data follows the registered address one cycle later.
module tb_pb_channel_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode, playback_en, din;
  logic        write_addr, write_stop_addr, write_ram, write_hp, loop_pb;
  logic [19:0] addr_in, stop_addr_in;
  logic        ram_rdata;
  logic [19:0] ram_addr;
  logic        ram_we, ram_wdata, dout, busy, done;

  logic mem [16];
  bit   pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr[3:0]] <= ram_wdata;
  assign ram_rdata = mem[ram_addr[3:0]];

  pb_channel_sequencer #(.ADDR_W(20), .HP_W(20)) dut (
    .clk(clk), .rst(rst), .mode(mode), .playback_en(playback_en), .din(din),
    .write_addr(write_addr), .write_stop_addr(write_stop_addr),
    .write_ram(write_ram), .write_hp(write_hp), .loop_pb(loop_pb),
    .addr_in(addr_in), .stop_addr_in(stop_addr_in), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .dout(dout), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stop(input logic [19:0] v);
    stop_addr_in = v; write_stop_addr = 1'b1; tick();
    write_stop_addr = 1'b0; tick();
  endtask

  task automatic set_hp(input logic [19:0] v);
    addr_in = v; write_hp = 1'b1; tick();
    write_hp = 1'b0; tick();
  endtask

  task automatic set_ptr(input logic [19:0] v);
    addr_in = v; write_addr = 1'b1; tick();
    write_addr = 1'b0; tick();
  endtask

  task automatic do_write(input logic v, input logic [19:0] exp_addr);
    din = v; write_ram = 1'b1; tick();
    check("wr_we", ram_we, 1);
    check("wr_addr", ram_addr, exp_addr);
    check("wr_data", ram_wdata, v);
    write_ram = 1'b0; tick();
    check("wr_we_low", ram_we, 0);
  endtask

  // Starts playback and checks dout/ram_addr for `cycles` clocks after T0.
  task automatic run_pb(input int h, input int n, input bit lp, input int cycles);
    loop_pb = lp; mode = 1'b1; playback_en = 1'b1; tick();
    check("t0_busy", busy, 1);
    check("t0_addr", ram_addr, 0);
    for (int c = 1; c <= cycles; c++) begin
      tick();
      check("pb_dout", dout, pat[((c - 1) / h) % n]);
      check("pb_addr", ram_addr, ((c - 1) / h + 1) % n);
      check("pb_busy", busy, 1);
      check("pb_done", done, 0);
    end
  endtask

  task automatic abort_pb();
    playback_en = 1'b0; tick();
    check("abort_dout", dout, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; playback_en = 1'b0; din = 1'b0; loop_pb = 1'b0;
    write_addr = 1'b0; write_stop_addr = 1'b0; write_ram = 1'b0; write_hp = 1'b0;
    addr_in = '0; stop_addr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", ram_addr, 0);
    check("rst_we", ram_we, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Load 1,0,1,1 at 0..3, then a held-high strobe yields one pulse at 4.
    set_ptr(20'd0);
    for (int i = 0; i < 4; i++) do_write(pat[i], 20'(i));
    din = 1'b0; write_ram = 1'b1; tick();
    check("hold_we", ram_we, 1);
    check("hold_addr", ram_addr, 4);
    repeat (2) begin
      tick();
      check("hold_we_once", ram_we, 0);
    end
    write_ram = 1'b0; tick();

    // One-shot, hp=5, stop=3: 20 clocks of data, DONE at T21.
    set_stop(20'd3);
    set_hp(20'd5);
    run_pb(5, 4, 1'b0, 20);
    tick();
    check("os_dout", dout, 0);
    check("os_done", done, 1);
    check("os_busy", busy, 0);
    repeat (3) begin
      tick();
      check("os_done_hold", done, 1);
    end
    abort_pb();

    // Loop twice round; config strobes during RUN must be ignored.
    run_pb(5, 4, 1'b1, 40);
    addr_in = 20'd9; write_addr = 1'b1; write_ram = 1'b1; din = 1'b1;
    repeat (2) begin
      tick();
      check("run_no_we", ram_we, 0);
      check("run_busy", busy, 1);
    end
    write_addr = 1'b0; write_ram = 1'b0;
    abort_pb();
    mode = 1'b0; tick();
    do_write(1'b1, 20'd5);

    // hp=0 clamps to 2.
    set_hp(20'd0);
    run_pb(2, 4, 1'b0, 8);
    tick();
    check("clamp_done", done, 1);
    check("clamp_dout", dout, 0);
    abort_pb();

    // stop=0 looped holds sample[0]; abort via mode=0.
    mode = 1'b0; tick();
    set_stop(20'd0);
    run_pb(2, 1, 1'b1, 10);
    mode = 1'b0; tick();
    check("mode_abort_dout", dout, 0);
    check("mode_abort_busy", busy, 0);
    playback_en = 1'b0; tick();

    // Async reset mid-RUN, off the clock edge.
    set_stop(20'd3);
    set_hp(20'd5);
    run_pb(5, 4, 1'b1, 7);
    #2 rst = 1'b1;
    #1;
    check("arst_dout", dout, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", ram_addr, 0);
    check("arst_we", ram_we, 0);
    check("arst_done", done, 0);
    playback_en = 1'b0; mode = 1'b0;
    #2 rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);
    run_pb(2, 1, 1'b0, 2);
    tick();
    check("post_rst_done", done, 1);
    check("post_rst_dout", dout, 0);
    abort_pb();
    mode = 1'b0; tick();

    // Same-cycle pointer load plus write, then pointer wrap at the top.
    addr_in = 20'd8; din = 1'b1; write_addr = 1'b1; write_ram = 1'b1; tick();
    check("both_we", ram_we, 1);
    check("both_addr", ram_addr, 8);
    write_addr = 1'b0; write_ram = 1'b0; tick();
    do_write(1'b0, 20'd9);
    set_ptr(20'hFFFFF);
    do_write(1'b1, 20'hFFFFF);
    do_write(1'b1, 20'h00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
